rep5_serial_tx: RTL and testbench

Serial repetition-code transmitter: accepts a parallel data word over a valid/ready handshake and emits it LSB-first on a one-bit line, with every data bit repeated REP consecutive times. It is the sending end of the 5-way majority-vote link. The receiver votes over each group of REP symbols, so up to (REP-1)/2 corrupted copies per bit are tolerated. It sits between the switch/register front end and the serial line toward the voter.

---
 rtl/rep5_serial_tx_pkg.sv | 16 +
 rtl/rep5_serial_tx_symbol_counter.sv | 41 ++++
 rtl/rep5_serial_tx.sv | 87 ++++++++
 tb/tb_rep5_serial_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rep5_serial_tx_pkg.sv
// Shared types and defaults for the repetition-code serial transmitter.
package rep_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_REP    = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int frame_len(input int data_w, input int rep);
        return data_w * rep;
    endfunction

endpackage

// File: rtl/rep5_serial_tx_symbol_counter.sv
// Copy/bit position tracker for one frame; strobes mark the last copy of a bit
// and the last copy of the final bit.
module rep_symbol_counter #(
    parameter int DATA_W = 8,
    parameter int REP    = 5,
    parameter int REP_W  = $clog2(REP),
    parameter int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_bit_done,
    output logic o_frame_done
);

    logic [REP_W-1:0] r_rep_cnt;
    logic [BIT_W-1:0] r_bit_cnt;

    assign o_bit_done   = (r_rep_cnt == REP_W'(REP - 1));
    assign o_frame_done = o_bit_done && (r_bit_cnt == BIT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            r_rep_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (i_advance) begin
            if (o_bit_done) begin
                r_rep_cnt <= '0;
                // Park at zero after the final bit so a non-power-of-two width never wraps oddly.
                r_bit_cnt <= o_frame_done ? '0 : r_bit_cnt + 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rep5_serial_tx.sv
// Repetition-code transmitter: sends a word LSB-first, each bit repeated REP times,
// over a valid/ready serial symbol stream.
module rep5_serial_tx
    import rep_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REP    = DEF_REP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              tx_ready,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              busy
);

    if ((REP % 2) == 0 || REP < 3) begin : g_bad_rep
        $error("rep5_serial_tx: REP must be odd and >= 3");
    end
    if (DATA_W < 1) begin : g_bad_width
        $error("rep5_serial_tx: DATA_W must be >= 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic              w_accept;
    logic              w_xfer;
    logic              w_bit_done;
    logic              w_frame_done;

    rep_symbol_counter #(
        .DATA_W (DATA_W),
        .REP    (REP)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_accept),
        .i_advance    (w_xfer),
        .o_bit_done   (w_bit_done),
        .o_frame_done (w_frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    w_xfer = 1'b1;
                    if (w_frame_done) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_shift <= '0;
        else if (w_accept)             r_shift <= data_in;
        else if (w_xfer && w_bit_done) r_shift <= r_shift >> 1;
    end

    // Every output decodes registered state only, so the line never sees valid_in/data_in directly.
    assign ready_out = (r_state == IDLE);
    assign busy      = (r_state == SEND);
    assign tx_valid  = busy;
    assign tx_bit    = busy & r_shift[0];
    assign tx_last   = busy & w_frame_done;

endmodule

// File: tb/tb_rep5_serial_tx.sv
// Self-checking bench for rep5_serial_tx: directed and randomized frames against a
// symbol-index reference model, plus a DATA_W=4/REP=3 instance with majority-vote recovery.
module tb_rep5_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx_ready;
    logic       tx_bit;
    logic       tx_valid;
    logic       tx_last;
    logic       busy;

    logic [3:0] data2;
    logic       valid2;
    logic       ready2;
    logic       tx_ready2;
    logic       tx_bit2;
    logic       tx_valid2;
    logic       tx_last2;
    logic       busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rep5_serial_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx_ready  (tx_ready),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .busy      (busy)
    );

    rep5_serial_tx #(.DATA_W(4), .REP(3)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data2),
        .valid_in  (valid2),
        .ready_out (ready2),
        .tx_ready  (tx_ready2),
        .tx_bit    (tx_bit2),
        .tx_valid  (tx_valid2),
        .tx_last   (tx_last2),
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready_out"}, ready_out, 1);
        check({tag, " tx_valid"},  tx_valid,  0);
        check({tag, " tx_last"},   tx_last,   0);
        check({tag, " busy"},      busy,      0);
        check({tag, " tx_bit"},    tx_bit,    0);
    endtask

    // Caller sits at a negedge; the word is accepted on the next posedge.
    task automatic start_frame(input logic [7:0] d);
        check("accept ready_out", ready_out, 1);
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready, 1: directed stalls, 2: random ready, 3: mid-frame valid pulse.
    // Reference: transferred symbol k carries d[k/5]; symbol 39 is the last.
    task automatic stream(input logic [7:0] d, input int mode, input int abort_at,
                          input logic nxt_valid, input logic [7:0] nxt_data);
        int k = 0;
        int cyc = 0;
        int stall_rem = 0;
        bit s3 = 0, s39 = 0, injected = 0;
        valid_in = nxt_valid;
        data_in  = nxt_data;
        while (k < 40 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check($sformatf("sym%0d tx_valid", k), tx_valid, 1);
            check($sformatf("sym%0d tx_bit", k),   tx_bit,   d[k/5]);
            check($sformatf("sym%0d tx_last", k),  tx_last,  (k == 39));
            check($sformatf("sym%0d busy", k),     busy,     1);
            check($sformatf("sym%0d ready_out", k), ready_out, 0);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle("async reset");
                tx_ready = 1'b1;
                valid_in = 1'b0;
                return;
            end
            tx_ready = 1'b1;
            case (mode)
                1: begin
                    if (stall_rem > 0) begin
                        tx_ready = 1'b0;
                        stall_rem--;
                    end else if (k == 3 && !s3) begin
                        s3 = 1; tx_ready = 1'b0; stall_rem = 2;
                    end else if (k == 39 && !s39) begin
                        s39 = 1; tx_ready = 1'b0; stall_rem = 1;
                    end
                end
                2: tx_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    if (k == 20 && !injected) begin
                        injected = 1; valid_in = 1'b1; data_in = 8'h00;
                    end else begin
                        valid_in = 1'b0;
                    end
                end
                default: tx_ready = 1'b1;
            endcase
            @(posedge clk);
            if (tx_ready) k++;
        end
        check("frame transfer count", k, 40);
        tx_ready = 1'b1;
        @(negedge clk);
        check("gap ready_out", ready_out, 1);
        check("gap tx_valid",  tx_valid,  0);
        check("gap busy",      busy,      0);
        check("gap tx_last",   tx_last,   0);
    endtask

    initial begin
        logic [7:0] rd;
        logic [11:0] sym;
        logic [3:0] rec;
        int ones;
        int p;

        rst_n = 1'b0;
        data_in = '0; valid_in = 1'b0; tx_ready = 1'b1;
        data2 = '0;   valid2 = 1'b0;   tx_ready2 = 1'b1;
        #2;
        check_idle("reset");
        check("reset dut2 ready", ready2, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post reset");

        // Basic frame
        start_frame(8'hA5);
        stream(8'hA5, 0, -1, 1'b0, 8'h00);

        // Downstream stalls at symbol 3 and on the last symbol
        start_frame(8'h01);
        stream(8'h01, 1, -1, 1'b0, 8'h00);

        // Valid pulse while busy must be ignored
        start_frame(8'hFF);
        stream(8'hFF, 3, -1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no second frame tx_valid", tx_valid, 0);
            check("no second frame ready_out", ready_out, 1);
        end

        // Back-to-back with valid held high
        start_frame(8'h0F);
        stream(8'h0F, 0, -1, 1'b1, 8'hF0);
        @(posedge clk);
        #1;
        stream(8'hF0, 0, -1, 1'b0, 8'h00);

        // Reset mid-frame, then a clean frame
        start_frame(8'h96);
        stream(8'h96, 0, 17, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(8'h3C);
        stream(8'h3C, 0, -1, 1'b0, 8'h00);

        // Randomized words with random downstream backpressure
        for (int f = 0; f < 6; f++) begin
            rd = 8'($urandom);
            start_frame(rd);
            stream(rd, (f % 2 == 0) ? 2 : 0, -1, 1'b0, 8'h00);
        end

        // Small variant: DATA_W=4, REP=3, then majority vote with one flip per group
        @(negedge clk);
        check("dut2 ready", ready2, 1);
        valid2 = 1'b1;
        data2  = 4'b1001;
        @(posedge clk);
        #1;
        valid2 = 1'b0;
        data2  = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("v sym%0d tx_valid", i), tx_valid2, 1);
            check($sformatf("v sym%0d tx_bit", i),   tx_bit2,   ((4'b1001 >> (i / 3)) & 4'b0001));
            check($sformatf("v sym%0d tx_last", i),  tx_last2,  (i == 11));
            sym[i] = tx_bit2;
            @(posedge clk);
        end
        @(negedge clk);
        check("v gap ready", ready2, 1);
        check("v gap tx_valid", tx_valid2, 0);
        for (int b = 0; b < 4; b++) begin
            p = $urandom_range(0, 2);
            ones = 0;
            for (int c = 0; c < 3; c++)
                ones += ((c == p) ? ~sym[b*3+c] : sym[b*3+c]) ? 1 : 0;
            rec[b] = (ones >= 2);
        end
        check("v majority recovered", rec, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
